// File: rtl/hub75_pkg.sv
// hub75_pkg: shared FSM state encodings and default panel geometry for the HUB75 framebuffer loader
package hub75_pkg;
  localparam int DEF_N_BANKS  = 2;
  localparam int DEF_N_ROWS   = 32;
  localparam int DEF_N_COLS   = 64;
  localparam int DEF_N_CHANS  = 3;
  localparam int DEF_N_PLANES = 8;
  localparam logic [2:0] S_FILL      = 3'd0;
  localparam logic [2:0] S_WAIT_RDY  = 3'd1;
  localparam logic [2:0] S_STORE     = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_SWAP      = 3'd4;
endpackage

// File: rtl/hub75_fb_loader_cnt.sv
// hub75_fb_loader_cnt: raster position counter (column, raster row, last-column/last-row flags)
//   inc_i      accepted pixel, advances column (wraps after N_COLS-1)
//   row_inc_i  advance raster row;  row_clr_i  restart at row 0
//   resync_i   start-of-frame resync: column 1, row 0 (pixel itself lands at column 0)
//   col_o/row_o current position;  last_col_o/last_row_o position flags
module hub75_fb_loader_cnt #(
  parameter int N_COLS       = 64,
  parameter int N_ROWS_TOTAL = 64,
  parameter int RW           = $clog2(N_ROWS_TOTAL),
  localparam int CW          = $clog2(N_COLS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc_i,
  input  logic          row_inc_i,
  input  logic          row_clr_i,
  input  logic          resync_i,
  output logic [CW-1:0] col_o,
  output logic [RW-1:0] row_o,
  output logic          last_col_o,
  output logic          last_row_o
);
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  assign last_col_o = col_q == CW'(N_COLS - 1);
  assign last_row_o = row_q == RW'(N_ROWS_TOTAL - 1);
  assign col_d = resync_i ? CW'(1) : inc_i ? (last_col_o ? '0 : col_q + CW'(1)) : col_q;
  assign row_d = (resync_i || row_clr_i) ? '0 : row_inc_i ? row_q + RW'(1) : row_q;
  assign col_o = col_q;
  assign row_o = row_q;
  always_ff @(posedge clk)
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
endmodule

// File: rtl/hub75_fb_loader.sv
// hub75_fb_loader: fills a line buffer from a raster pixel stream and requests row stores / frame swaps
//   in_data/in_sof/in_valid/in_ready   pixel stream (transfer when in_valid && in_ready)
//   wr_data/wr_col_addr/wr_en          line-buffer write, one cycle after acceptance
//   wr_bank_addr/wr_row_addr           destination of the current row store
//   wr_row_swap/wr_row_store           one-cycle store request; wr_row_rdy grants it
//   frame_swap                         completed frame handed to the display
//   err_sync                           frame resync pulse
// Optional macro HUB75_FB_LOADER_SOF_EN: in_sof on an unexpected position resyncs to row 0.
module hub75_fb_loader import hub75_pkg::*; #(
  parameter int N_BANKS   = DEF_N_BANKS,
  parameter int N_ROWS    = DEF_N_ROWS,
  parameter int N_COLS    = DEF_N_COLS,
  parameter int N_CHANS   = DEF_N_CHANS,
  parameter int N_PLANES  = DEF_N_PLANES,
  localparam int LOG_N_BANKS = $clog2(N_BANKS),
  localparam int LOG_N_ROWS  = $clog2(N_ROWS),
  localparam int LOG_N_COLS  = $clog2(N_COLS),
  localparam int RW          = LOG_N_BANKS + LOG_N_ROWS,
  localparam int DW          = N_CHANS * N_PLANES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DW-1:0]          in_data,
  input  logic                   in_sof,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DW-1:0]          wr_data,
  output logic [LOG_N_COLS-1:0]  wr_col_addr,
  output logic                   wr_en,
  output logic [LOG_N_BANKS-1:0] wr_bank_addr,
  output logic [LOG_N_ROWS-1:0]  wr_row_addr,
  output logic                   wr_row_swap,
  output logic                   wr_row_store,
  input  logic                   wr_row_rdy,
  output logic                   frame_swap,
  output logic                   err_sync
);
  logic [2:0] state_q, state_d;
  logic first_q, acc, resync, wr_en_q, err_q, last_col, last_row;
  logic [LOG_N_COLS-1:0] col, wr_col_q;
  logic [RW-1:0] row;
  logic [DW-1:0] wr_data_q;
  logic [LOG_N_BANKS-1:0] bank_q;
  logic [LOG_N_ROWS-1:0] row_q;
  assign in_ready = state_q == S_FILL && !rst;
  assign acc = in_valid && in_ready;
`ifdef HUB75_FB_LOADER_SOF_EN
  assign resync = acc && in_sof && (col != '0 || row != '0);
`else
  logic unused_sof;
  assign unused_sof = in_sof;
  assign resync = 1'b0;
`endif
  // Both wait states ignore wr_row_rdy in their first cycle: in WAIT_RDY the last
  // pixel's line-buffer write is still landing, in WAIT_DONE the final store is.
  assign state_d = state_q == S_FILL      ? (acc && last_col && !resync ? S_WAIT_RDY : S_FILL)
                 : state_q == S_WAIT_RDY  ? (wr_row_rdy && !first_q ? S_STORE : S_WAIT_RDY)
                 : state_q == S_STORE     ? (last_row ? S_WAIT_DONE : S_FILL)
                 : state_q == S_WAIT_DONE ? (wr_row_rdy && !first_q ? S_SWAP : S_WAIT_DONE)
                 : S_FILL;
  hub75_fb_loader_cnt #(.N_COLS(N_COLS), .N_ROWS_TOTAL(N_BANKS * N_ROWS), .RW(RW)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .inc_i      (acc),
    .row_inc_i  (state_q == S_STORE && !last_row),
    .row_clr_i  (state_q == S_SWAP),
    .resync_i   (resync),
    .col_o      (col),
    .row_o      (row),
    .last_col_o (last_col),
    .last_row_o (last_row)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state_q   <= S_FILL;
      first_q   <= 1'b1;
      wr_en_q   <= 1'b0;
      err_q     <= 1'b0;
      wr_data_q <= '0;
      wr_col_q  <= '0;
      bank_q    <= '0;
      row_q     <= '0;
    end else begin
      state_q <= state_d;
      first_q <= state_d != state_q;
      wr_en_q <= acc;
      err_q   <= resync;
      if (acc) begin
        wr_data_q <= in_data;
        wr_col_q  <= resync ? '0 : col;
      end
      // Destination latched on entry to STORE so it stays put while the next row fills.
      if (state_d == S_STORE && state_q != S_STORE) begin
        bank_q <= row[RW-1 -: LOG_N_BANKS];
        row_q  <= row[LOG_N_ROWS-1:0];
      end
    end
  assign wr_data      = wr_data_q;
  assign wr_col_addr  = wr_col_q;
  assign wr_bank_addr = bank_q;
  assign wr_row_addr  = row_q;
  assign wr_en        = wr_en_q && !rst;
  assign err_sync     = err_q && !rst;
  assign wr_row_store = state_q == S_STORE && !rst;
  assign wr_row_swap  = wr_row_store;
  assign frame_swap   = state_q == S_SWAP && !rst;
endmodule
